// File: rtl/fifo16_arb_queue_pkg.sv
// ---------------------------------------------------------------------------
// fifo16_pkg
// Shared constants and the storage entry type for the fifo16_arb_queue
// slice. CNT_W covers 0..DEPTH inclusive; IDX_W addresses one slot.
// ---------------------------------------------------------------------------
package fifo16_pkg;

  localparam int DEPTH = 16;
  localparam int CH_W  = 2;
  localparam int ID_W  = 4;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic [ID_W-1:0] id;
  } entry_t;

endpackage : fifo16_pkg

// File: rtl/fifo16_arb_queue_if.sv
// ---------------------------------------------------------------------------
// fifo16_arb_queue_if
// Bundles the push, grant and select signals of the arbiter request queue.
//   master : upstream/arbiter side, drives p_req_* and p_arb_*
//   slave  : the queue, drives p_sel_* (and the status outputs)
// Optional macro FIFO16_STATUS_EN adds p_full, p_count and p_drop.
// ---------------------------------------------------------------------------
interface fifo16_arb_queue_if;
  import fifo16_pkg::*;

  logic            p_req_val;
  logic [CH_W-1:0] p_req_ch;
  logic [ID_W-1:0] p_req_id;
  logic            p_arb_val;
  logic [CH_W-1:0] p_arb_ch;
  logic            p_sel_val;
  logic [ID_W-1:0] p_sel_req_id;
`ifdef FIFO16_STATUS_EN
  logic             p_full;
  logic [CNT_W-1:0] p_count;
  logic             p_drop;
`endif

  modport master (
    output p_req_val, p_req_ch, p_req_id, p_arb_val, p_arb_ch,
`ifdef FIFO16_STATUS_EN
    input  p_full, p_count, p_drop,
`endif
    input  p_sel_val, p_sel_req_id
  );

  modport slave (
    input  p_req_val, p_req_ch, p_req_id, p_arb_val, p_arb_ch,
`ifdef FIFO16_STATUS_EN
    output p_full, p_count, p_drop,
`endif
    output p_sel_val, p_sel_req_id
  );

endinterface : fifo16_arb_queue_if

// File: rtl/fifo16_arb_queue_first_match.sv
// ---------------------------------------------------------------------------
// fifo16_first_match
// Combinational lowest-index priority encoder: finds the first valid slot
// whose channel equals ch_t_i.
//   vld_i  : per-slot valid bits
//   ch_i   : per-slot channel fields
//   ch_t_i : target channel
//   hit_o  : a matching slot exists
//   idx_o  : index of the lowest matching slot (0 when no hit)
// ---------------------------------------------------------------------------
module fifo16_first_match
  import fifo16_pkg::*;
(
  input  logic [DEPTH-1:0]           vld_i,
  input  logic [DEPTH-1:0][CH_W-1:0] ch_i,
  input  logic [CH_W-1:0]            ch_t_i,
  output logic                       hit_o,
  output logic [IDX_W-1:0]           idx_o
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_i[i] && (ch_i[i] == ch_t_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule : fifo16_first_match

// File: rtl/fifo16_arb_queue.sv
// ---------------------------------------------------------------------------
// fifo16_arb_queue
// Shared age-ordered request queue for a 4-channel arbiter. Pushes append
// {ch,id}; a grant removes the oldest entry of the granted channel and
// presents its id on the registered select output one cycle later.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fifo16_arb_queue_if.slave (push, grant, select, status)
// Optional macro FIFO16_STATUS_EN adds p_full, p_count and p_drop.
// ---------------------------------------------------------------------------
module fifo16_arb_queue
  import fifo16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fifo16_arb_queue_if.slave  bus
);

  entry_t [DEPTH-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sel_val_q, sel_val_d;
  logic [ID_W-1:0]    sel_id_q, sel_id_d;

  logic [DEPTH-1:0]           slot_vld;
  logic [DEPTH-1:0][CH_W-1:0] slot_ch;
  logic                       match_hit;
  logic [IDX_W-1:0]           match_idx;
  logic                       pop_hit;
  logic                       full;
  logic                       push_ok;
  logic [CNT_W-1:0]           wr_ptr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_vld[i] = slots_q[i].vld;
      slot_ch[i]  = slots_q[i].ch;
    end
  end

  // Search only pre-edge contents: an incoming push is never bypassed.
  fifo16_first_match u_first_match (
    .vld_i  (slot_vld),
    .ch_i   (slot_ch),
    .ch_t_i (bus.p_arb_ch),
    .hit_o  (match_hit),
    .idx_o  (match_idx)
  );

  assign pop_hit = bus.p_arb_val && match_hit;
  assign full    = (count_q == CNT_W'(DEPTH));
  // A hit-pop frees a slot in the same edge, so a push into a full queue
  // is still accepted then.
  assign push_ok = bus.p_req_val && (!full || pop_hit);
  assign wr_ptr  = pop_hit ? (count_q - CNT_W'(1)) : count_q;

  always_comb begin
    slots_d   = slots_q;
    count_d   = count_q;
    sel_val_d = 1'b0;
    sel_id_d  = '0;

    if (pop_hit) begin
      sel_val_d = 1'b1;
      sel_id_d  = slots_q[match_idx].id;
      // Storage is compacted, so shifting everything above k keeps order.
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= match_idx) begin
          slots_d[i] = slots_q[i+1];
        end
      end
      slots_d[DEPTH-1] = '0;
      count_d = count_q - CNT_W'(1);
    end

    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_ptr) begin
          slots_d[i].vld = 1'b1;
          slots_d[i].ch  = bus.p_req_ch;
          slots_d[i].id  = bus.p_req_id;
        end
      end
      count_d = pop_hit ? count_q : (count_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q   <= '0;
      count_q   <= '0;
      sel_val_q <= 1'b0;
      sel_id_q  <= '0;
    end else begin
      slots_q   <= slots_d;
      count_q   <= count_d;
      sel_val_q <= sel_val_d;
      sel_id_q  <= sel_id_d;
    end
  end

  assign bus.p_sel_val    = sel_val_q;
  assign bus.p_sel_req_id = sel_id_q;

`ifdef FIFO16_STATUS_EN
  logic drop_q, drop_d;

  assign drop_d = bus.p_req_val && !push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.p_full  = full;
  assign bus.p_count = count_q;
  assign bus.p_drop  = drop_q;
`endif

endmodule : fifo16_arb_queue

// File: tb/tb_fifo16_arb_queue.sv
// ---------------------------------------------------------------------------
// tb_fifo16_arb_queue
// Directed bench for fifo16_arb_queue. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 time unit after the following edge.
// Define FIFO16_STATUS_EN to also check p_full, p_count and p_drop.
// ---------------------------------------------------------------------------
module tb_fifo16_arb_queue;
  import fifo16_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  fifo16_arb_queue_if u_if ();

  fifo16_arb_queue u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus and advance past the edge that samples it.
  task automatic cyc(input logic rv, input logic [CH_W-1:0] rc, input logic [ID_W-1:0] ri,
                     input logic av, input logic [CH_W-1:0] ac);
    u_if.p_req_val = rv;
    u_if.p_req_ch  = rc;
    u_if.p_req_id  = ri;
    u_if.p_arb_val = av;
    u_if.p_arb_ch  = ac;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string tag, input logic v, input logic [ID_W-1:0] id);
    chk({tag, "_val"}, 32'(u_if.p_sel_val), 32'(v));
    chk({tag, "_id"}, 32'(u_if.p_sel_req_id), 32'(id));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;

    // Reset held two cycles, then a grant on the empty queue.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_sel("rst", 0, 0);
`ifdef FIFO16_STATUS_EN
    chk("rst_count", 32'(u_if.p_count), 0);
    chk("rst_full", 32'(u_if.p_full), 0);
    chk("rst_drop", 32'(u_if.p_drop), 0);
`endif
    rst = 1'b0;
    cyc(0, 0, 0, 1, 0);
    chk_sel("empty_grant", 0, 0);

    // Ordered push/pop.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 2, 3, 1, 0);
    chk_sel("ord_ch0", 1, 1);
    cyc(0, 0, 0, 1, 2);
    chk_sel("ord_ch2", 1, 3);
    cyc(0, 0, 0, 1, 1);
    chk_sel("ord_ch1a", 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk_sel("ord_ch1b", 1, 2);
    cyc(0, 0, 0, 0, 0);
    chk_sel("ord_idle", 0, 0);

    // Miss leaves the queue untouched.
    cyc(1, 1, 5, 0, 0);
    cyc(1, 1, 6, 0, 0);
    cyc(0, 0, 0, 1, 3);
    chk_sel("miss", 0, 0);
`ifdef FIFO16_STATUS_EN
    chk("miss_count", 32'(u_if.p_count), 2);
`endif
    cyc(0, 0, 0, 1, 1);
    chk_sel("miss_after1", 1, 5);
    cyc(0, 0, 0, 1, 1);
    chk_sel("miss_after2", 1, 6);

    // Same-cycle push and grant on an empty queue: no bypass.
    cyc(1, 2, 7, 1, 2);
    chk_sel("nobypass", 0, 0);
    cyc(0, 0, 0, 1, 2);
    chk_sel("nobypass_next", 1, 7);

    // Fill to DEPTH with ch0 ids 0..15.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, ID_W'(i), 0, 0);
    end
`ifdef FIFO16_STATUS_EN
    chk("full_flag", 32'(u_if.p_full), 1);
    chk("full_count", 32'(u_if.p_count), DEPTH);
`endif
    cyc(1, 1, 4'hA, 0, 0);
    chk_sel("drop_sel", 0, 0);
`ifdef FIFO16_STATUS_EN
    chk("drop_pulse", 32'(u_if.p_drop), 1);
    chk("drop_count", 32'(u_if.p_count), DEPTH);
`endif
    cyc(1, 1, 4'hB, 1, 0);
    chk_sel("full_pushpop", 1, 0);
`ifdef FIFO16_STATUS_EN
    chk("pushpop_drop", 32'(u_if.p_drop), 0);
    chk("pushpop_count", 32'(u_if.p_count), DEPTH);
`endif
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk_sel("drain", 1, ID_W'(i));
    end
    cyc(0, 0, 0, 1, 0);
    chk_sel("drain_done", 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk_sel("idB", 1, 4'hB);
    cyc(0, 0, 0, 1, 1);
    chk_sel("idA_gone", 0, 0);
`ifdef FIFO16_STATUS_EN
    chk("empty_count", 32'(u_if.p_count), 0);
`endif

    // Mid-operation reset with a grant in the reset cycle.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 2, 3, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 0);
    chk_sel("midrst", 0, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 0, 1, CH_W'(c));
      chk_sel("post_rst", 0, 0);
    end
`ifdef FIFO16_STATUS_EN
    chk("post_rst_count", 32'(u_if.p_count), 0);
`endif

    cyc(0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_fifo16_arb_queue
